// File: rtl/corevx_loadunit.sv
// Load unit: accepts byte/half/word loads, issues one aligned bus read, returns aligned+extended data.
// Optional bus timeout enabled by defining COREVX_LOADUNIT_TIMEOUT_EN.
module corevx_loadunit (
   input  logic        clk,
   input  logic        rst,
   input  logic        loadReqValid,
   output logic        loadReqReady,
   input  logic [31:0] loadAddr,
   input  logic [2:0]  loadType,
   output logic        memReadEn,
   output logic [31:0] memAddr,
   input  logic        memReady,
   input  logic [31:0] memRData,
   input  logic        memError,
   output logic        loadRespValid,
   output logic [31:0] loadData,
   output logic        loadMissAligned,
   output logic        loadUnknownType,
   output logic        loadBusError,
   output logic        loadTimeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;

   logic [1:0]  state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] waddr_q, waddr_d;
   logic [2:0]  type_q, type_d;
   logic [31:0] data_q, data_d;
   logic        mis_q, mis_d;
   logic        unk_q, unk_d;
   logic        berr_q, berr_d;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
   logic [3:0]  cnt_q, cnt_d;
   logic        tmo_q, tmo_d;
`endif

   logic        req_known;
   logic        req_mis;
   logic [31:0] shifted;
   logic [31:0] extended;

   always_comb begin
      req_known = 1'b1;
      req_mis   = 1'b0;
      case (loadType)
         LT_LB, LT_LBU: req_mis = 1'b0;
         LT_LH, LT_LHU: req_mis = loadAddr[0];
         LT_LW:         req_mis = |loadAddr[1:0];
         default:       req_known = 1'b0;
      endcase
   end

   // Extraction uses the latched offset/type, so the request inputs may change freely during BUS.
   always_comb begin
      shifted  = memRData >> {off_q, 3'b000};
      extended = shifted;
      case (type_q)
         LT_LB:   extended = {{24{shifted[7]}}, shifted[7:0]};
         LT_LH:   extended = {{16{shifted[15]}}, shifted[15:0]};
         LT_LBU:  extended = {24'd0, shifted[7:0]};
         LT_LHU:  extended = {16'd0, shifted[15:0]};
         default: extended = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      waddr_d = waddr_q;
      type_d  = type_q;
      data_d  = data_q;
      mis_d   = mis_q;
      unk_d   = unk_q;
      berr_d  = berr_q;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (loadReqValid) begin
               off_d   = loadAddr[1:0];
               waddr_d = loadAddr[31:2];
               type_d  = loadType;
               data_d  = 32'd0;
               mis_d   = req_known & req_mis;
               unk_d   = ~req_known;
               berr_d  = 1'b0;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
               cnt_d   = 4'd0;
               tmo_d   = 1'b0;
`endif
               state_d = (!req_known || req_mis) ? ST_RESP : ST_BUS;
            end
         end
         ST_BUS: begin
            if (memReady) begin
               berr_d  = memError;
               data_d  = memError ? 32'd0 : extended;
               state_d = ST_RESP;
            end
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
            // The counter shows the number of completed idle BUS cycles; the 15th idle cycle times out.
            else if (cnt_q == 4'd14) begin
               cnt_d   = 4'd15;
               tmo_d   = 1'b1;
               data_d  = 32'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
`endif
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         off_q   <= 2'd0;
         waddr_q <= 30'd0;
         type_q  <= 3'd0;
         data_q  <= 32'd0;
         mis_q   <= 1'b0;
         unk_q   <= 1'b0;
         berr_q  <= 1'b0;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
         cnt_q   <= 4'd0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         waddr_q <= waddr_d;
         type_q  <= type_d;
         data_q  <= data_d;
         mis_q   <= mis_d;
         unk_q   <= unk_d;
         berr_q  <= berr_d;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Outputs are gated by rst so they read zero during reset regardless of the state register.
   assign loadReqReady    = ~rst & (state_q == ST_IDLE);
   assign memReadEn       = ~rst & (state_q == ST_BUS);
   assign memAddr         = memReadEn ? {waddr_q, 2'b00} : 32'd0;
   assign loadRespValid   = ~rst & (state_q == ST_RESP);
   assign loadData        = loadRespValid ? data_q : 32'd0;
   assign loadMissAligned = loadRespValid & mis_q;
   assign loadUnknownType = loadRespValid & unk_q;
   assign loadBusError    = loadRespValid & berr_q;
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
   assign loadTimeout     = loadRespValid & tmo_q;
`else
   assign loadTimeout     = 1'b0;
`endif

endmodule

// File: tb/tb_corevx_loadunit.sv
// Randomized + directed bench for corevx_loadunit against a behavioural load model.
// Define COREVX_LOADUNIT_TIMEOUT_EN to also exercise the bus timeout.
module tb_corevx_loadunit;

   logic        clk = 1'b0;
   logic        rst;
   logic        loadReqValid;
   logic        loadReqReady;
   logic [31:0] loadAddr;
   logic [2:0]  loadType;
   logic        memReadEn;
   logic [31:0] memAddr;
   logic        memReady;
   logic [31:0] memRData;
   logic        memError;
   logic        loadRespValid;
   logic [31:0] loadData;
   logic        loadMissAligned;
   logic        loadUnknownType;
   logic        loadBusError;
   logic        loadTimeout;

   int checks = 0;
   int errors = 0;

   corevx_loadunit dut (
      .clk            (clk),
      .rst            (rst),
      .loadReqValid   (loadReqValid),
      .loadReqReady   (loadReqReady),
      .loadAddr       (loadAddr),
      .loadType       (loadType),
      .memReadEn      (memReadEn),
      .memAddr        (memAddr),
      .memReady       (memReady),
      .memRData       (memRData),
      .memError       (memError),
      .loadRespValid  (loadRespValid),
      .loadData       (loadData),
      .loadMissAligned(loadMissAligned),
      .loadUnknownType(loadUnknownType),
      .loadBusError   (loadBusError),
      .loadTimeout    (loadTimeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_known(input logic [2:0] t);
      return (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd4) || (t == 3'd5);
   endfunction

   function automatic bit is_mis(input logic [2:0] t, input logic [1:0] off);
      if (t == 3'd2) return off != 2'd0;
      if (t == 3'd1 || t == 3'd5) return (int'(off) % 2) == 1;
      return 1'b0;
   endfunction

   // Load result from plain integer arithmetic: select the byte lane, then extend by value.
   function automatic logic [31:0] ref_data(input logic [2:0] t, input logic [1:0] off, input logic [31:0] rd);
      longint v;
      longint b;
      longint h;
      v = longint'(rd) / (longint'(1) << (8 * int'(off)));
      b = v % 256;
      h = v % 65536;
      case (t)
         3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return rd;
      endcase
   endfunction

   task automatic do_load(input string name, input logic [2:0] t, input logic [31:0] addr,
                          input int waits, input logic [31:0] rd, input logic err);
      bit known, mis, done, tmo;
      logic [31:0] exp_data;
      known = is_known(t);
      mis   = known && is_mis(t, addr[1:0]);
      done  = 1'b0;
      tmo   = 1'b0;
      @(negedge clk);
      chk($sformatf("%s.ready", name), 32'(loadReqReady), 32'd1);
      chk($sformatf("%s.rv_idle", name), 32'(loadRespValid), 32'd0);
      loadReqValid = 1'b1;
      loadAddr     = addr;
      loadType     = t;
      memReady     = 1'($urandom_range(1));
      memRData     = $urandom;
      memError     = 1'($urandom_range(1));
      @(negedge clk);
      loadReqValid = 1'b0;
      loadAddr     = $urandom;
      loadType     = 3'($urandom_range(7));
      if (!known || mis) begin
         memReady = 1'b0;
         chk($sformatf("%s.ren", name), 32'(memReadEn), 32'd0);
         chk($sformatf("%s.rv", name), 32'(loadRespValid), 32'd1);
         chk($sformatf("%s.mis", name), 32'(loadMissAligned), 32'(mis));
         chk($sformatf("%s.unk", name), 32'(loadUnknownType), 32'(!known));
         chk($sformatf("%s.berr", name), 32'(loadBusError), 32'd0);
         chk($sformatf("%s.tmo", name), 32'(loadTimeout), 32'd0);
         chk($sformatf("%s.data", name), loadData, 32'd0);
      end else begin
         for (int k = 0; k < 40 && !done; k++) begin
            chk($sformatf("%s.ren%0d", name, k), 32'(memReadEn), 32'd1);
            chk($sformatf("%s.addr%0d", name, k), memAddr, addr & 32'hFFFF_FFFC);
            chk($sformatf("%s.rvbus%0d", name, k), 32'(loadRespValid), 32'd0);
            if (k == waits) begin
               memReady = 1'b1;
               memRData = rd;
               memError = err;
               done     = 1'b1;
            end else begin
               memReady = 1'b0;
               memRData = $urandom;
               memError = 1'($urandom_range(1));
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
               if (k == 14) begin
                  tmo  = 1'b1;
                  done = 1'b1;
               end
`endif
            end
            @(negedge clk);
         end
         memReady = 1'b0;
         if (!done) chk($sformatf("%s.bus_bound", name), 32'd0, 32'd1);
         exp_data = (tmo || err) ? 32'd0 : ref_data(t, addr[1:0], rd);
         chk($sformatf("%s.ren_resp", name), 32'(memReadEn), 32'd0);
         chk($sformatf("%s.rv", name), 32'(loadRespValid), 32'd1);
         chk($sformatf("%s.data", name), loadData, exp_data);
         chk($sformatf("%s.mis", name), 32'(loadMissAligned), 32'd0);
         chk($sformatf("%s.unk", name), 32'(loadUnknownType), 32'd0);
         chk($sformatf("%s.berr", name), 32'(loadBusError), 32'(err && !tmo));
         chk($sformatf("%s.tmo", name), 32'(loadTimeout), 32'(tmo));
      end
      $display("txn %s type=%0d addr=%h waits=%0d data=%h", name, t, addr, waits, loadData);
   endtask

   task automatic reset_mid_bus();
      @(negedge clk);
      chk("rstbus.ready", 32'(loadReqReady), 32'd1);
      loadReqValid = 1'b1;
      loadAddr     = 32'h0000_5000;
      loadType     = 3'd2;
      @(negedge clk);
      loadReqValid = 1'b0;
      memReady     = 1'b0;
      chk("rstbus.ren", 32'(memReadEn), 32'd1);
      @(negedge clk);
      rst      = 1'b1;
      memReady = 1'b1;
      memRData = 32'hDEAD_BEEF;
      memError = 1'b0;
      @(negedge clk);
      memReady = 1'b0;
      chk("rstbus.ren_after", 32'(memReadEn), 32'd0);
      chk("rstbus.rv_after", 32'(loadRespValid), 32'd0);
      chk("rstbus.ready_inrst", 32'(loadReqReady), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstbus.ready_rel", 32'(loadReqReady), 32'd1);
      chk("rstbus.rv_rel", 32'(loadRespValid), 32'd0);
      chk("rstbus.ren_rel", 32'(memReadEn), 32'd0);
      $display("txn reset_mid_bus ready=%0d", loadReqReady);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      loadReqValid = 1'b0;
      loadAddr     = 32'd0;
      loadType     = 3'd0;
      memReady     = 1'b0;
      memRData     = 32'd0;
      memError     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.ready", 32'(loadReqReady), 32'd0);
      chk("rst.ren", 32'(memReadEn), 32'd0);
      chk("rst.maddr", memAddr, 32'd0);
      chk("rst.rv", 32'(loadRespValid), 32'd0);
      chk("rst.data", loadData, 32'd0);
      chk("rst.flags", {28'd0, loadMissAligned, loadUnknownType, loadBusError, loadTimeout}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.ready_first", 32'(loadReqReady), 32'd1);

      do_load("lb_1003", 3'd0, 32'h0000_1003, 0, 32'h80FF_1234, 1'b0);
      do_load("lhu_2002", 3'd5, 32'h0000_2002, 3, 32'h8001_5555, 1'b0);
      do_load("lw_mis", 3'd2, 32'h0000_3001, 0, 32'd0, 1'b0);
      do_load("unk_011", 3'd3, 32'h0000_3000, 0, 32'd0, 1'b0);
      do_load("lw_berr", 3'd2, 32'h0000_4000, 0, 32'h1234_5678, 1'b1);
      do_load("lh_mis", 3'd1, 32'h0000_4003, 0, 32'd0, 1'b0);
      do_load("lw_ok", 3'd2, 32'h0000_4004, 1, 32'hCAFE_F00D, 1'b0);
`ifdef COREVX_LOADUNIT_TIMEOUT_EN
      do_load("tmo", 3'd2, 32'h0000_6000, 100, 32'd0, 1'b0);
      do_load("tmo_edge", 3'd0, 32'h0000_6001, 14, 32'h0000_9900, 1'b0);
`endif
      reset_mid_bus();

      for (int i = 0; i < 60; i++) begin
         do_load($sformatf("rnd%0d", i), 3'($urandom_range(7)), $urandom,
                 int'($urandom_range(4)), $urandom, ($urandom_range(7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/corevx_loadunit.md
COREVX_LOADUNIT -- requirements
Module: corevx_loadunit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port loadReqValid, input, 1 bit: a load request is presented.
REQ-004 SHALL have port loadReqReady, output, 1 bit: the unit accepts a request this cycle.
REQ-005 SHALL have port loadAddr, input, 32 bits: byte address of the load.
REQ-006 SHALL have port loadType, input, 3 bits: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are unknown.
REQ-007 SHALL have port memReadEn, output, 1 bit: bus read request.
REQ-008 SHALL have port memAddr, output, 32 bits: word-aligned bus address.
REQ-009 SHALL have port memReady, input, 1 bit: bus read completes this cycle.
REQ-010 SHALL have port memRData, input, 32 bits: bus read data, valid only when memReady=1.
REQ-011 SHALL have port memError, input, 1 bit: bus error, sampled only when memReady=1.
REQ-012 SHALL have port loadRespValid, output, 1 bit: single-cycle response strobe.
REQ-013 SHALL have port loadData, output, 32 bits: the aligned and extended load result.
REQ-014 SHALL have port loadMissAligned, output, 1 bit: misaligned-access flag.
REQ-015 SHALL have port loadUnknownType, output, 1 bit: unknown-type flag.
REQ-016 SHALL have port loadBusError, output, 1 bit: bus-error flag.
REQ-017 SHALL have port loadTimeout, output, 1 bit: bus-timeout flag.

Function
REQ-018 SHALL implement a state machine with three states: IDLE, BUS and RESP.
REQ-019 SHALL drive loadReqReady=1 only in IDLE; a request is accepted on a cycle with loadReqValid=1 and loadReqReady=1, and the unit latches loadAddr[1:0], the word address and loadType.
REQ-020 SHALL set misaligned as follows: LW when offset!=0, LH/LHU when offset[0]=1, never for LB/LBU.
REQ-021 SHALL handle a misaligned or unknown-type accepted request as IDLE->RESP with the matching flag set and no bus access; an unknown type sets only loadUnknownType.
REQ-022 SHALL handle any other accepted request as IDLE->BUS.
REQ-023 SHALL, in BUS, hold memReadEn=1 and memAddr={addr[31:2],2'b00} stable until memReady=1; on that edge it captures the result and moves to RESP.
REQ-024 SHALL form the result by shifting memRData right by offset*8, then sign-extending from bit 7 (LB) or bit 15 (LH), or zero-extending (LBU/LHU); LW passes all 32 bits.
REQ-025 SHALL assert loadRespValid for exactly one cycle in RESP, with data and flags stable that cycle, then return to IDLE; there is no response backpressure.
REQ-026 SHALL provide minimum latency of: accept at cycle N, memReadEn at N+1, memReady at N+1, loadRespValid at N+2; the error path without bus access gives loadRespValid at N+1.
REQ-027 SHALL drive loadData=0 whenever any error flag is set, including memError=1.
REQ-028 SHALL ignore memReady outside BUS.
REQ-029 SHALL keep memReadEn=0 outside BUS.

Reset
REQ-030 SHALL, while rst=1, force state IDLE and drive loadReqReady=0, memReadEn=0, memAddr=0, loadRespValid=0, loadData=0 and all flags=0.
REQ-031 SHALL, on reset in BUS or RESP, abort the operation and drop any pending response; memReadEn is 0 after that edge.
REQ-032 SHALL drive loadReqReady=1 on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, with COREVX_LOADUNIT_TIMEOUT_EN defined, implement a 4-bit counter that clears on entry to BUS and increments each BUS cycle without memReady.
REQ-034 SHALL, with COREVX_LOADUNIT_TIMEOUT_EN defined, move BUS->RESP when the counter reaches 15 without memReady, with loadTimeout=1 and loadData=0; memReady=1 on that same cycle takes priority, so there is no timeout.
REQ-035 SHALL, without COREVX_LOADUNIT_TIMEOUT_EN, wait in BUS indefinitely and tie loadTimeout to 0.

Verification
REQ-036 SHALL cover LB: addr 0x1003, memRData=0x80FF_1234 with memReady at first BUS cycle -> memAddr=0x1000, loadData=0xFFFF_FF80, loadRespValid at accept+2.
REQ-037 SHALL cover LHU: addr 0x2002, memRData=0x8001_5555 with 3 wait cycles -> memReadEn held 4 cycles, loadData=0x0000_8001, no flags.
REQ-038 SHALL cover LW misaligned and unknown type: LW at 0x3001 -> loadMissAligned=1, memReadEn never asserted, response at accept+1; type 011 -> loadUnknownType=1 only.
REQ-039 SHALL cover bus error: LW at 0x4000, memReady=1 with memError=1 -> loadBusError=1, loadData=0.
REQ-040 SHALL cover timeout with macro: memReady held 0 -> loadTimeout=1 after 15 BUS cycles; memReady=1 on counter 15 -> normal data and loadTimeout=0.
REQ-041 SHALL cover reset mid-BUS: rst pulsed during wait -> no loadRespValid, memReadEn=0 next cycle, loadReqReady=1 after release.
